// File: rtl/radix2_divider_core_pkg.sv
// Shared types for the radix-2 restoring divider: operation codes, data width and FSM states.
package radix2_divider_core_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic [1:0] div_code_path_t;
  localparam div_code_path_t DIV_CODE_DIV  = 2'd0;
  localparam div_code_path_t DIV_CODE_DIVU = 2'd1;
  localparam div_code_path_t DIV_CODE_REM  = 2'd2;
  localparam div_code_path_t DIV_CODE_REMU = 2'd3;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_FIXUP,
    DIV_DONE
  } div_state_t;

  function automatic logic div_code_is_signed(input div_code_path_t code);
    return (code == DIV_CODE_DIV) || (code == DIV_CODE_REM);
  endfunction

  function automatic logic div_code_is_rem(input div_code_path_t code);
    return code[1];
  endfunction

endpackage

// File: rtl/radix2_divider_core_divider_step.sv
// Combinational UNROLL-bit restoring divide step on unsigned magnitudes, MSB first.
module radix2_divider_core_divider_step
  import radix2_divider_core_pkg::*;
#(
  parameter int BIT_WIDTH = DATA_WIDTH,
  parameter int UNROLL    = 1
) (
  input  logic [BIT_WIDTH-1:0] rem_in,
  input  logic [BIT_WIDTH-1:0] quo_in,
  input  logic [BIT_WIDTH-1:0] divisor,
  output logic [BIT_WIDTH-1:0] rem_out,
  output logic [BIT_WIDTH-1:0] quo_out
);

  logic [BIT_WIDTH-1:0] rem_v;
  logic [BIT_WIDTH-1:0] quo_v;
  logic [BIT_WIDTH:0]   trial;
  logic [BIT_WIDTH:0]   diff;

  // The quotient register starts out holding the dividend; its MSB feeds the remainder
  // while the new quotient bit enters at the LSB. diff's top bit is the borrow.
  always_comb begin
    rem_v = rem_in;
    quo_v = quo_in;
    trial = '0;
    diff  = '0;
    for (int i = 0; i < UNROLL; i++) begin
      trial = {rem_v, quo_v[BIT_WIDTH-1]};
      diff  = trial - {1'b0, divisor};
      quo_v = {quo_v[BIT_WIDTH-2:0], ~diff[BIT_WIDTH]};
      rem_v = diff[BIT_WIDTH] ? trial[BIT_WIDTH-1:0] : diff[BIT_WIDTH-1:0];
    end
    rem_out = rem_v;
    quo_out = quo_v;
  end

endmodule

// File: rtl/radix2_divider_core.sv
// Iterative restoring DIV/DIVU/REM/REMU core, UNROLL quotient bits per cycle.
// Optional RSD_DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iterations.
module radix2_divider_core
  import radix2_divider_core_pkg::*;
#(
  parameter int BIT_WIDTH = DATA_WIDTH,
  parameter int UNROLL    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [BIT_WIDTH-1:0] fuOpA_In,
  input  logic [BIT_WIDTH-1:0] fuOpB_In,
  input  div_code_path_t       divCode,
  output logic                 finished,
  output logic [BIT_WIDTH-1:0] dataOut
);

  localparam int ITER  = BIT_WIDTH / UNROLL;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [BIT_WIDTH-1:0] MIN_VAL  = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  function automatic logic [BIT_WIDTH-1:0] apply_sign(input logic [BIT_WIDTH-1:0] mag,
                                                       input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  div_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 finished_q, finished_d;
  logic [BIT_WIDTH-1:0] data_out_q, data_out_d;
  logic [BIT_WIDTH-1:0] rem_q, rem_d;
  logic [BIT_WIDTH-1:0] quo_q, quo_d;
  logic [BIT_WIDTH-1:0] divisor_q, divisor_d;
  div_code_path_t       code_q, code_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic                 div0_q, div0_d;
  logic                 ovf_q, ovf_d;

  logic                        signed_op;
  logic                        sign_a, sign_b;
  logic signed [BIT_WIDTH-1:0] op_a_s, op_b_s;
  logic [BIT_WIDTH-1:0]        step_rem, step_quo;
  logic [BIT_WIDTH-1:0]        q_fix, r_fix;

  radix2_divider_core_divider_step #(
    .BIT_WIDTH(BIT_WIDTH),
    .UNROLL   (UNROLL)
  ) u_divider_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(divisor_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  assign op_a_s = fuOpA_In;
  assign op_b_s = fuOpB_In;

  always_comb begin
    signed_op  = div_code_is_signed(divCode);
    sign_a     = signed_op & op_a_s[BIT_WIDTH-1];
    sign_b     = signed_op & op_b_s[BIT_WIDTH-1];
    // |MIN| stays correct as an unsigned value, so no guard bit is needed.
    q_fix      = div0_q ? '1 : (ovf_q ? MIN_VAL : apply_sign(quo_q, negq_q));
    r_fix      = ovf_q ? '0 : apply_sign(rem_q, negr_q);

    state_d    = state_q;
    cnt_d      = cnt_q;
    finished_d = finished_q;
    data_out_d = data_out_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    code_d     = code_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    div0_d     = div0_q;
    ovf_d      = ovf_q;

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (req) begin
          quo_d      = sign_a ? BIT_WIDTH'(-op_a_s) : fuOpA_In;
          divisor_d  = sign_b ? BIT_WIDTH'(-op_b_s) : fuOpB_In;
          rem_d      = '0;
          negq_d     = sign_a ^ sign_b;
          negr_d     = sign_a;
          code_d     = divCode;
          div0_d     = (fuOpB_In == '0);
          ovf_d      = signed_op && (fuOpA_In == MIN_VAL) && (fuOpB_In == '1);
          cnt_d      = CNT_LAST;
          finished_d = 1'b0;
          state_d    = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
`ifdef RSD_DIV_FAST_SPECIAL_EN
        // quo_q still holds |A| here, which is the divide-by-zero remainder magnitude.
        if (div0_q || ovf_q) begin
          rem_d   = div0_q ? quo_q : '0;
          quo_d   = div0_q ? '1 : MIN_VAL;
          cnt_d   = '0;
          state_d = DIV_FIXUP;
        end else begin
`else
        begin
`endif
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DIV_FIXUP;
          end
        end
      end
      DIV_FIXUP: begin
        data_out_d = div_code_is_rem(code_q) ? r_fix : q_fix;
        finished_d = 1'b1;
        state_d    = DIV_DONE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      finished_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      finished_q <= finished_d;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    divisor_q <= divisor_d;
    code_q    <= code_d;
    negq_q    <= negq_d;
    negr_q    <= negr_d;
    div0_q    <= div0_d;
    ovf_q     <= ovf_d;
  end

  assign finished = finished_q;
  assign dataOut  = data_out_q;

endmodule

// File: tb/tb_radix2_divider_core.sv
// Directed plus small random bench for radix2_divider_core with a result scoreboard.
module tb_radix2_divider_core;
  import radix2_divider_core_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;
`ifdef RSD_DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 33;
`endif
  localparam int NORMAL_LAT = 33;

  logic           clk = 1'b0;
  logic           rst;
  logic           req;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  div_code_path_t code;
  logic           finished;
  logic [W-1:0]   data_out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] data;
    int           lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  radix2_divider_core dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .fuOpA_In(op_a),
    .fuOpB_In(op_b),
    .divCode (code),
    .finished(finished),
    .dataOut (data_out)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] model(input div_code_path_t c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] da;
    logic signed [W-1:0] db;
    logic                is_rem;
    da     = a;
    db     = b;
    is_rem = (c == DIV_CODE_REM) || (c == DIV_CODE_REMU);
    if (b == '0) return is_rem ? a : '1;
    if (c == DIV_CODE_DIV || c == DIV_CODE_REM) begin
      if (a == MIN_V && b == '1) return is_rem ? '0 : MIN_V;
      return is_rem ? W'(da % db) : W'(da / db);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input div_code_path_t c, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] expv, input bit noise);
    exp_t e;
    int   cyc;
    logic special;
    special = (xb == '0) ||
              ((c == DIV_CODE_DIV || c == DIV_CODE_REM) && xa == MIN_V && xb == '1);
    e.tag  = tag;
    e.data = expv;
    e.lat  = special ? SPECIAL_LAT : NORMAL_LAT;
    sb.push_back(e);
    code = c;
    op_a = xa;
    op_b = xb;
    req  = 1'b1;
    tick();
    req  = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    code = div_code_path_t'($urandom_range(0, 3));
    check({tag, "_drop"}, {31'b0, finished}, '0);
    cyc = 0;
    while (finished !== 1'b1 && cyc < 100) begin
      req = (noise && (cyc == 4 || cyc == 17)) ? 1'b1 : 1'b0;
      if (req) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      tick();
      cyc++;
    end
    req = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_lat"}, W'(cyc), W'(e.lat));
    check({e.tag, "_data"}, data_out, e.data);
  endtask

  task automatic watch_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (finished !== 1'b0) seen = 1'b1;
    end
    check(tag, {31'b0, seen}, '0);
  endtask

  initial begin
    div_code_path_t rc;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    rst  = 1'b1;
    req  = 1'b0;
    op_a = '0;
    op_b = '0;
    code = DIV_CODE_DIV;
    repeat (3) tick();
    check("rst_finished", {31'b0, finished}, '0);
    check("rst_data", data_out, '0);
    rst = 1'b0;
    tick();
    check("idle_finished", {31'b0, finished}, '0);

    run_op("div_100_7", DIV_CODE_DIV, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("rem_100_7", DIV_CODE_REM, 32'd100, 32'd7, 32'd2, 1'b0);
    repeat (5) tick();
    check("hold_finished", {31'b0, finished}, 32'd1);
    check("hold_data", data_out, 32'd2);

    run_op("div_m100_7", DIV_CODE_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
    run_op("rem_m100_7", DIV_CODE_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("rem_100_m7", DIV_CODE_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_max_2", DIV_CODE_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 1'b0);
    run_op("remu_max_2", DIV_CODE_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);

    run_op("div_5_0", DIV_CODE_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_5_0", DIV_CODE_REMU, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("div_m5_0", DIV_CODE_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_m5_0", DIV_CODE_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0);
    run_op("div_ovf", DIV_CODE_DIV, MIN_V, 32'hFFFF_FFFF, MIN_V, 1'b0);
    run_op("rem_ovf", DIV_CODE_REM, MIN_V, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("divu_min_1", DIV_CODE_DIVU, MIN_V, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Abort an in-flight op at cycle 10.
    code = DIV_CODE_DIV;
    op_a = 32'd1000;
    op_b = 32'd3;
    req  = 1'b1;
    tick();
    req = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_finished", {31'b0, finished}, '0);
    check("abort_data", data_out, '0);
    watch_quiet("abort_quiet");

    // Reset and request together: the request is dropped.
    code = DIV_CODE_DIV;
    op_a = 32'd77;
    op_b = 32'd7;
    rst  = 1'b1;
    req  = 1'b1;
    tick();
    rst = 1'b0;
    req = 1'b0;
    watch_quiet("rst_req_quiet");

    run_op("div_9_3", DIV_CODE_DIV, 32'd9, 32'd3, 32'd3, 1'b0);
    run_op("busy_noise", DIV_CODE_DIV, 32'd1000, 32'd10, 32'd100, 1'b1);
    run_op("busy_noise_rem", DIV_CODE_REMU, 32'd12345, 32'd100, 32'd45, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rc = div_code_path_t'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'(ra >> 7) : $urandom_range(1, 100000);
      run_op($sformatf("rand%0d", i), rc, ra, rb, model(rc, ra, rb), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
